mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives every datapath enable and mux select, and it generates the 2-bit ALUOp consumed by the ALU control decoder. It sits between the instruction register's opcode field and the datapath control inputs.

Parameters:
OPC_RTYPE, 6'h00, R-type opcode
OPC_LW, 6'h23, load word
OPC_SW, 6'h2B, store word
OPC_BEQ, 6'h04, branch if equal
OPC_ADDI, 6'h08, add immediate
OPC_J, 6'h02, jump

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero flag (branch)
branch_ne  out  1  invert zero condition (see Optional Feature)
i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
reg_dst  out  1  destination register: 0 = rt, 1 = rd
reg_write  out  1  register file write
alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2
alu_op  out  2  00 = add, 01 = sub, 10 = decode by function field, 11 = unused (never driven)
pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
illegal  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state encoding (debug)

Behaviour:
- Moore machine. All outputs are a pure function of the registered state. Opcode only affects the next state.
- Any output not listed for a state is 0.
- States and their outputs:
  - IDLE = 0: all outputs 0.
  - FETCH = 1: mem_read, ir_write, pc_write; alu_src_b = 01; alu_op = 00; pc_source = 00.
  - DECODE = 2: alu_src_b = 11; alu_op = 00 (branch target into ALUOut).
  - MEMADR = 3: alu_src_a = 1; alu_src_b = 10; alu_op = 00.
  - MEMRD = 4: mem_read; i_or_d = 1.
  - MEMWB = 5: reg_write; mem_to_reg = 1; reg_dst = 0.
  - MEMWR = 6: mem_write; i_or_d = 1.
  - EXEC = 7: alu_src_a = 1; alu_src_b = 00; alu_op = 10.
  - ALUWB = 8: reg_write; reg_dst = 1; mem_to_reg = 0.
  - BRANCH = 9: alu_src_a = 1; alu_src_b = 00; alu_op = 01; pc_write_cond; pc_source = 01.
  - ADDIEX = 10: alu_src_a = 1; alu_src_b = 10; alu_op = 00.
  - ADDIWB = 11: reg_write; reg_dst = 0; mem_to_reg = 0.
  - JUMP = 12: pc_write; pc_source = 10.
  - ILLEGAL = 13: illegal = 1.
- Transitions:
  - IDLE -> FETCH -> DECODE.
  - DECODE branches on opcode: LW or SW -> MEMADR; RTYPE -> EXEC; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP; any other opcode -> ILLEGAL.
  - MEMADR -> MEMRD if opcode = LW, else MEMWR.
  - MEMRD -> MEMWB.
  - EXEC -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP and ILLEGAL all go -> FETCH.
- Encodings 14 and 15 are unreachable. If entered, they output all 0 and go -> FETCH next cycle.
- Instruction cycle counts, FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3. The PC is not modified by an illegal opcode beyond its FETCH increment.
- Reset:
  - rst_n = 0 sampled at an edge forces IDLE on that edge, regardless of current state, including mid-instruction.
  - Outputs are all 0 from that edge until the first edge with rst_n = 1, which moves the FSM to FETCH.
  - Reset aborts an in-flight instruction with no partial writeback. The write strobes are already 0 in IDLE.
- Opcode is ignored in every state except DECODE and MEMADR. Changes elsewhere have no effect.
- Mutual exclusion invariants, every cycle: mem_read & mem_write = 0; at most one of pc_write, pc_write_cond asserted; reg_write never asserted together with mem_write.

Optional Feature:
Macro MC_CTRL_BNE_EN adds opcode 6'h05 (bne).
- Defined: DECODE with opcode 6'h05 -> BRANCH. In BRANCH, branch_ne = 1 when the decoded instruction is bne, else 0. The FSM keeps this in a 1-bit register loaded in DECODE. All other BRANCH outputs are identical to beq.
- Not defined: branch_ne is tied to 0; 6'h05 is illegal (DECODE -> ILLEGAL); no extra flop.

Test Plan:
- Reset then run: hold rst_n = 0 for 3 cycles -> state = 0 and all outputs 0. Release -> next edge state = 1 (FETCH) with mem_read = 1, ir_write = 1, pc_write = 1, alu_src_b = 01.
- lw: opcode = 6'h23 -> states 1,2,3,4,5,1. State 3 shows alu_op = 00, alu_src_b = 10. State 5 shows reg_write = 1, mem_to_reg = 1.
- R-type then sw: opcode = 0 -> 1,2,7,8 with alu_op = 10 in state 7 and reg_dst = 1 in state 8. Then opcode = 6'h2B -> 1,2,3,6 with mem_write = 1, i_or_d = 1 in state 6.
- beq / j / addi: 6'h04 -> 1,2,9 with alu_op = 01, pc_write_cond = 1, pc_source = 01. 6'h02 -> 1,2,12 with pc_source = 10. 6'h08 -> 1,2,10,11 with reg_dst = 0.
- Illegal and bne: opcode = 6'h3F -> 1,2,13 with illegal = 1 for exactly one cycle, then 1. opcode = 6'h05 -> state 9 with branch_ne = 1 if MC_CTRL_BNE_EN is defined, else state 13.
- Reset mid-instruction: drop rst_n in state 4 of lw -> state 0 next edge, reg_write never asserted. Release -> state 1. The mutual-exclusion invariants are checked every cycle of every test.

Source files
------------

// File: rtl/mc_main_control_if.sv
// Control bundle between the main control FSM (master) and the multi-cycle datapath (slave).
// The datapath supplies the IR opcode field; the FSM returns every enable, mux select and debug state.
interface mc_main_control_if;
    logic [5:0] opcode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal, state
    );

    modport slave (
        output opcode,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal, state
    );
endinterface

// File: rtl/mc_main_control.sv
// Moore main-control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Optional bne support is enabled by defining MC_CTRL_BNE_EN.
module mc_main_control #(
    parameter logic [5:0] OPC_RTYPE = 6'h00,
    parameter logic [5:0] OPC_LW    = 6'h23,
    parameter logic [5:0] OPC_SW    = 6'h2B,
    parameter logic [5:0] OPC_BEQ   = 6'h04,
    parameter logic [5:0] OPC_ADDI  = 6'h08,
    parameter logic [5:0] OPC_J     = 6'h02
) (
    input logic             clk,
    input logic             rst_n,
    mc_main_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Opcode is only consulted in DECODE and MEMADR; every other state has a fixed successor.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OPC_LW || bus.opcode == OPC_SW) state_d = S_MEMADR;
                else if (bus.opcode == OPC_RTYPE)                 state_d = S_EXEC;
                else if (bus.opcode == OPC_BEQ)                   state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                else if (bus.opcode == 6'h05)                     state_d = S_BRANCH;
`endif
                else if (bus.opcode == OPC_ADDI)                  state_d = S_ADDIEX;
                else if (bus.opcode == OPC_J)                     state_d = S_JUMP;
                else                                              state_d = S_ILLEGAL;
            end
            S_MEMADR: state_d = (bus.opcode == OPC_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = 2'b01;
            end
            // Branch target is precomputed into ALUOut while the opcode is decoded.
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            S_ILLEGAL: bus.illegal = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_CTRL_BNE_EN
    // Remembers whether the branch being executed was decoded as bne.
    logic bne_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                  bne_q <= 1'b0;
        else if (state_q == S_DECODE) bne_q <= (bus.opcode == 6'h05);
    end

    assign bus.branch_ne = (state_q == S_BRANCH) & bne_q;
`else
    assign bus.branch_ne = 1'b0;
`endif

    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Randomized bench for mc_main_control: instruction-level model expands each opcode into its
// expected per-cycle control vectors; one compare process checks every cycle plus the invariants.
module tb_mc_main_control;

    localparam int W = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic check_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    logic [W-1:0] exp_q[$];

    mc_main_control_if bus();

    mc_main_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: actual %h required %h", name, cyc, act, req);
    endtask

    // Control vector for one cycle, taken straight from the state output table.
    function automatic logic [W-1:0] ctrl_vec(input logic [3:0] st, input logic bne);
        logic pcw, pcwc, bn, iord, mr, mw, irw, m2r, rdst, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, bn, iord, mr, mw, irw, m2r, rdst, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd1:  begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iord = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; bn = bne; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd12: begin pcw = 1; psrc = 2'b10; end
            4'd13: ill = 1;
            default: ;
        endcase
        return {st, pcw, pcwc, bn, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
    endfunction

    // State walk of one instruction, FETCH first; returns its cycle count.
    function automatic int plan(input logic [5:0] op, output logic [4:0][3:0] seq, output logic bne);
        int len;
        seq = '0;
        seq[0] = 4'd1;
        seq[1] = 4'd2;
        bne = 1'b0;
        len = 3;
        case (op)
            6'h23: begin seq[2] = 4'd3; seq[3] = 4'd4; seq[4] = 4'd5; len = 5; end
            6'h2B: begin seq[2] = 4'd3; seq[3] = 4'd6; len = 4; end
            6'h00: begin seq[2] = 4'd7; seq[3] = 4'd8; len = 4; end
            6'h08: begin seq[2] = 4'd10; seq[3] = 4'd11; len = 4; end
            6'h04: seq[2] = 4'd9;
            6'h02: seq[2] = 4'd12;
`ifdef MC_CTRL_BNE_EN
            6'h05: begin seq[2] = 4'd9; bne = 1'b1; end
`endif
            default: seq[2] = 4'd13;
        endcase
        return len;
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {bus.state, bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                bus.illegal};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            cyc++;
            if (exp_q.size() == 0) begin
                check("expected_queue_empty", 32'd1, 32'd0);
            end else begin
                check("ctrl_vector", 32'(dut_vec()), 32'(exp_q.pop_front()));
            end
            check("mem_rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
            check("pc_write_excl", 32'(bus.pc_write & bus.pc_write_cond), 32'd0);
            check("reg_wr_mem_wr_excl", 32'(bus.reg_write & bus.mem_write), 32'd0);
        end
    end

    // abort_at >= 0 drops reset in that cycle of the instruction (0 = FETCH).
    task automatic run_instr(input logic [5:0] op, input int abort_at, input bit pin_fetch);
        logic [4:0][3:0] seq;
        logic bne;
        int len;
        len = plan(op, seq, bne);
        for (int i = 0; i < len; i++) exp_q.push_back(ctrl_vec(seq[i], bne));
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            if (pin_fetch && k == 0)
                check("fetch_after_release",
                      32'({bus.state, bus.mem_read, bus.ir_write, bus.pc_write, bus.alu_src_b}),
                      32'({4'd1, 1'b1, 1'b1, 1'b1, 2'b01}));
            if (k == 1 || k == 2) bus.opcode = op;
            else                  bus.opcode = 6'($urandom_range(0, 63));
            if (k == abort_at) begin
                rst_n = 1'b0;
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                exp_q.push_back('0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 8))
            0: return 6'h00;
            1: return 6'h23;
            2: return 6'h2B;
            3: return 6'h04;
            4: return 6'h08;
            5: return 6'h02;
            6: return 6'h05;
            7: return 6'h3F;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        logic [4:0][3:0] s;
        logic b;
        logic [5:0] op;
        int len;

        bus.opcode = 6'h00;
        check("len_lw", 32'(plan(6'h23, s, b)), 32'd5);
        check("len_sw", 32'(plan(6'h2B, s, b)), 32'd4);
        check("len_rtype", 32'(plan(6'h00, s, b)), 32'd4);
        check("len_addi", 32'(plan(6'h08, s, b)), 32'd4);
        check("len_beq", 32'(plan(6'h04, s, b)), 32'd3);
        check("len_j", 32'(plan(6'h02, s, b)), 32'd3);
        check("len_illegal", 32'(plan(6'h3F, s, b)), 32'd3);

        rst_n = 1'b0;
        check_en = 1'b1;
        repeat (3) exp_q.push_back('0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(6'h23, -1, 1'b1);
        run_instr(6'h00, -1, 1'b0);
        run_instr(6'h2B, -1, 1'b0);
        run_instr(6'h04, -1, 1'b0);
        run_instr(6'h02, -1, 1'b0);
        run_instr(6'h08, -1, 1'b0);
        run_instr(6'h3F, -1, 1'b0);
        run_instr(6'h05, -1, 1'b0);
        run_instr(6'h23, 3, 1'b0);
        run_instr(6'h04, -1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            op = pick_op();
            len = plan(op, s, b);
            if ($urandom_range(0, 11) == 0) run_instr(op, int'($urandom_range(0, len - 1)), 1'b0);
            else                            run_instr(op, -1, 1'b0);
        end

        @(negedge clk);
        #1;
        check_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
